// File: rtl/alu_share_arbiter_if.sv
// Request, response and ALU-side bundle of the shared ALU arbiter.
// master = issue logic / ALU side, slave = alu_share_arbiter.
interface alu_share_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_ctrl;
  logic [XLEN-1:0]  req0_a;
  logic [XLEN-1:0]  req0_b;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_ctrl;
  logic [XLEN-1:0]  req1_a;
  logic [XLEN-1:0]  req1_b;
  logic [TAG_W-1:0] req1_tag;

  logic [3:0]       alu_ctrl;
  logic [XLEN-1:0]  alu_a;
  logic [XLEN-1:0]  alu_b;
  logic [XLEN-1:0]  alu_result;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [XLEN-1:0]  rsp0_result;
  logic [TAG_W-1:0] rsp0_tag;

  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [XLEN-1:0]  rsp1_result;
  logic [TAG_W-1:0] rsp1_tag;

  logic             busy;

  modport master (
    output req0_valid, req0_ctrl, req0_a,
    output req0_b, req0_tag,
    output req1_valid, req1_ctrl, req1_a,
    output req1_b, req1_tag,
    output alu_result,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  alu_ctrl, alu_a, alu_b,
    input  rsp0_valid, rsp0_result, rsp0_tag,
    input  rsp1_valid, rsp1_result, rsp1_tag,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_ctrl, req0_a,
    input  req0_b, req0_tag,
    input  req1_valid, req1_ctrl, req1_a,
    input  req1_b, req1_tag,
    input  alu_result,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output alu_ctrl, alu_a, alu_b,
    output rsp0_valid, rsp0_result, rsp0_tag,
    output rsp1_valid, rsp1_result, rsp1_tag,
    output busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters.
// Optional grant/conflict counters under `ALU_SHARE_STATS_EN.
module alu_share_arbiter #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 4,
  parameter int ALU_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  alu_share_arbiter_if.slave bus
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [15:0] grant0_cnt,
  output logic [15:0] grant1_cnt,
  output logic [15:0] conflict_cnt
`endif
);

  generate
    if (ALU_LAT < 1 || ALU_LAT > 7) begin : g_bad_lat
      $error("ALU_LAT must be 1..7");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state;
  logic [2:0]       cnt;
  logic             last_grant;
  logic             owner;
  logic [TAG_W-1:0] tag_q;

  logic idle;
  logic g0;
  logic g1;
  logic own_ready;

  assign idle = (state == IDLE);

  // On contention the side that did not win last time gets the ALU.
  assign g0 = idle & bus.req0_valid
            & (~bus.req1_valid | last_grant);
  assign g1 = idle & bus.req1_valid
            & (~bus.req0_valid | ~last_grant);

  assign bus.req0_ready = g0;
  assign bus.req1_ready = g1;
  assign bus.busy       = ~idle;

  assign own_ready = owner ? bus.rsp1_ready
                           : bus.rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      last_grant      <= 1'b1;
      owner           <= 1'b0;
      tag_q           <= '0;
      bus.alu_ctrl    <= '0;
      bus.alu_a       <= '0;
      bus.alu_b       <= '0;
      bus.rsp0_valid  <= 1'b0;
      bus.rsp0_result <= '0;
      bus.rsp0_tag    <= '0;
      bus.rsp1_valid  <= 1'b0;
      bus.rsp1_result <= '0;
      bus.rsp1_tag    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            g0: begin
              bus.alu_ctrl <= bus.req0_ctrl;
              bus.alu_a    <= bus.req0_a;
              bus.alu_b    <= bus.req0_b;
              tag_q        <= bus.req0_tag;
              owner        <= 1'b0;
              last_grant   <= 1'b0;
              cnt          <= 3'(ALU_LAT - 1);
              state        <= EXEC;
            end
            g1: begin
              bus.alu_ctrl <= bus.req1_ctrl;
              bus.alu_a    <= bus.req1_a;
              bus.alu_b    <= bus.req1_b;
              tag_q        <= bus.req1_tag;
              owner        <= 1'b1;
              last_grant   <= 1'b1;
              cnt          <= 3'(ALU_LAT - 1);
              state        <= EXEC;
            end
            default: ;
          endcase
        end
        EXEC: begin
          if (cnt == 3'd0) begin
            if (owner) begin
              bus.rsp1_result <= bus.alu_result;
              bus.rsp1_tag    <= tag_q;
              bus.rsp1_valid  <= 1'b1;
            end else begin
              bus.rsp0_result <= bus.alu_result;
              bus.rsp0_tag    <= tag_q;
              bus.rsp0_valid  <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (own_ready) begin
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SHARE_STATS_EN
  logic both;
  assign both = idle & bus.req0_valid & bus.req1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant0_cnt   <= '0;
      grant1_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (g0 && grant0_cnt != 16'hFFFF)
        grant0_cnt <= grant0_cnt + 16'd1;
      if (g1 && grant1_cnt != 16'hFFFF)
        grant1_cnt <= grant1_cnt + 16'd1;
      if (both && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one ALU instance between two requesters (req0 = integer pipeline, req1 = address/branch helper) using round-robin arbitration.
- Registers the granted operation and control code, then waits a fixed ALU latency. The result is captured and returned on the owner's response channel with valid/ready backpressure.
- Sits between the issue logic and the ALU datapath. ALUControl codes pass through undecoded.

Parameters:
- XLEN, 32: operand and result width.
- TAG_W, 4: width of the requester tag echoed with each result.
- ALU_LAT, 1: cycles from operand register update to a valid alu_result. Legal range 1..7; other values are illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  operation request.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_ctrl / req1_ctrl  in  4  ALUControl code (ADD=0000 ... SLTU=1001).
- req0_a / req1_a, req0_b / req1_b  in  XLEN  operands.
- req0_tag / req1_tag  in  TAG_W  requester tag.
- alu_ctrl  out  4  registered control code to the ALU.
- alu_a / alu_b  out  XLEN  registered operands to the ALU.
- alu_result  in  XLEN  ALU output.
- rsp0_valid / rsp1_valid  out  1  result available.
- rsp0_ready / rsp1_ready  in  1  consumer takes the result.
- rsp0_result / rsp1_result  out  XLEN  captured result.
- rsp0_tag / rsp1_tag  out  TAG_W  tag of the completed operation.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, every output register 0 (alu_ctrl=0000 i.e. ADD, alu_a=alu_b=0, rspN_valid=0, results/tags=0), cnt=0.
  - last_grant=1, so req0 wins the first contention.
- States: IDLE -> EXEC -> RESP -> IDLE. Only one operation is in flight.
- IDLE:
  - grant = the single valid requester. If both are valid, grant the one that is not last_grant.
  - reqN_ready = (state==IDLE) && grant==N && reqN_valid. This is combinational from valid and state; no ready is driven without valid.
  - On handshake: latch ctrl/a/b into alu_ctrl/alu_a/alu_b, latch tag and owner id, set last_grant=N, cnt=ALU_LAT-1, go to EXEC.
  - With no valid: stay in IDLE and hold the ALU registers at their last values (no toggling).
- EXEC:
  - If cnt==0: capture alu_result into the owner's rsp_result, set rspOwner_valid=1, go to RESP.
  - Otherwise decrement cnt.
- RESP:
  - rspOwner_valid stays high; result and tag are stable until accepted.
  - When rspOwner_ready is high: clear valid and go to IDLE. No new request is accepted in that same cycle.
  - Ready on the non-owner response channel is ignored.
- Timing:
  - Latency from request handshake at edge T to rsp_valid high is ALU_LAT+1 cycles.
  - Minimum initiation interval is ALU_LAT+2 cycles with the consumer always ready.
- Requester handshake rules:
  - A requester may drop valid before it is granted; this has no effect.
  - Operands are sampled only on the handshake edge; later changes are ignored.
- Fairness: under continuous requests from both sides, grants alternate strictly 0,1,0,1...
- Reset mid-operation (asserted in EXEC or RESP): the operation is discarded, rsp_valid drops immediately (async), and the state returns to the reset values.
- Control codes 1010..1111 are forwarded unchanged; the ALU defines the result.

Optional Feature:
- Macro: ALU_SHARE_STATS_EN.
- When defined, adds outputs grant0_cnt[15:0], grant1_cnt[15:0] and conflict_cnt[15:0].
  - grantN_cnt increments on each reqN handshake.
  - conflict_cnt increments on each IDLE cycle where both reqN_valid are high.
  - All three saturate at 16'hFFFF, reset to 0, and have no other effect on arbitration.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then req0 ADD a=5 b=7 tag=3, ALU_LAT=1, rsp0_ready=1 -> req0_ready high in cycle 0; rsp0_valid high at cycle 2 with result=12, tag=3; busy high for cycles 1..2.
- Both requesters valid continuously (req0 SUB 10-3, req1 XOR F0^0F) -> grant order req0, req1, req0, req1; results 7, FF alternating; req1 never starved.
- rsp1_ready held low for 5 cycles after rsp1_valid -> rsp1_valid, result and tag stable; req0_valid high meanwhile gets no ready until the cycle after rsp1_ready rises.
- ALU_LAT=3, req1 SLT a=-1 b=1 -> rsp1_valid exactly 4 cycles after the handshake, result=1.
- Assert rst_n low during EXEC -> rsp_valid, busy and alu_ctrl go to 0 immediately; the next request after release gets the full latency; req0 wins the first contention.
- With ALU_SHARE_STATS_EN: 3 req0 grants, 2 req1 grants, 2 conflict cycles -> grant0_cnt=3, grant1_cnt=2, conflict_cnt=2; force 65536 grants -> grant0_cnt holds at FFFF.
